// File: rtl/boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : boot_loader_ctrl
// Purpose  : Bootloader frame parser. Reads bytes from the UART receive FIFO
//            with a valid/ready handshake, validates a framed program image
//            (SYNC, LEN_LO, LEN_HI, LEN x 4 data bytes little-endian
//            [, CHK]) and writes it to IMEM as 32-bit words. The CPU is held
//            in reset until a complete image has been loaded.
// Ports    : clk, rst_n (async, active-low)
//            rx_byte/rx_valid/rx_ready  - FIFO read side
//            imem_we/imem_addr/imem_wdata - IMEM write port (1-cycle strobe)
//            boot_done / boot_err       - sticky status
//            cpu_rst_n                  - CPU reset, released on boot_done
// Config   : `define BOOT_CHECKSUM_EN to require the trailing XOR checksum
//            byte. Without it the frame ends after the last data word.
// Revision : 1.0 - initial release
// ============================================================================
module boot_loader_ctrl #(
  parameter int         ADDR_WIDTH     = 10,
  parameter int         BASE_ADDR      = 0,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  boot_done,
  output logic                  boot_err,
  output logic                  cpu_rst_n
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;
`ifdef BOOT_CHECKSUM_EN
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_AFTER  = S_CHK;   // state following the payload
`else
  localparam logic [2:0] S_AFTER  = S_DONE;
`endif

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             armed;       // holds rx_ready low for the first cycle out of reset
  logic             accept;
  logic             in_frame;
  logic             timeout;
  logic             last_byte;
  logic             len_too_big;
  logic [7:0]       len_lo;
  logic [15:0]      len;
  logic [15:0]      len_rx;
  logic [15:0]      word_idx;
  logic [1:0]       byte_idx;
  logic [23:0]      asm_word;    // lower three bytes of the word being assembled
  logic [CNT_W-1:0] idle_cnt;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign accept      = rx_valid && rx_ready;
  assign len_rx      = {rx_byte, len_lo};
  assign len_too_big = 32'(len_rx) > (32'd1 << ADDR_WIDTH);
  assign last_byte   = (byte_idx == 2'd3) && (word_idx == len - 16'd1);

`ifdef BOOT_CHECKSUM_EN
  assign in_frame = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                    (state == S_DATA)   || (state == S_CHK);
`else
  assign in_frame = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                    (state == S_DATA);
`endif

  // An accepted byte in the limit cycle takes priority over the timeout.
  assign timeout = in_frame && !accept && (idle_cnt == TO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && rx_byte == SYNC_BYTE) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept)       state_nxt = S_LEN_HI;
        else if (timeout) state_nxt = S_ERROR;
      end
      S_LEN_HI: begin
        if (accept) begin
          if (len_too_big)         state_nxt = S_ERROR;
          else if (len_rx == 16'd0) state_nxt = S_AFTER;
          else                      state_nxt = S_DATA;
        end else if (timeout) begin
          state_nxt = S_ERROR;
        end
      end
      S_DATA: begin
        if (accept) begin
          if (last_byte) state_nxt = S_AFTER;
        end else if (timeout) begin
          state_nxt = S_ERROR;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHK: begin
        if (accept)       state_nxt = (rx_byte == csum) ? S_DONE : S_ERROR;
        else if (timeout) state_nxt = S_ERROR;
      end
`endif
      default: state_nxt = state;   // DONE and ERROR are terminal
    endcase
  end

  // Output logic
  always_comb begin
    rx_ready  = 1'b0;
    boot_done = 1'b0;
    boot_err  = 1'b0;
    cpu_rst_n = 1'b0;
    case (state)
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA: rx_ready = armed;
`ifdef BOOT_CHECKSUM_EN
      S_CHK: rx_ready = armed;
`endif
      S_DONE: begin
        boot_done = 1'b1;
        cpu_rst_n = 1'b1;
      end
      S_ERROR: boot_err = 1'b1;
      default: rx_ready = 1'b0;
    endcase
  end

  // Datapath: length capture, word assembly, IMEM write, inter-byte counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed      <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      len_lo     <= '0;
      len        <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      asm_word   <= '0;
      idle_cnt   <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      armed   <= 1'b1;
      imem_we <= 1'b0;

      if (accept || !in_frame) idle_cnt <= '0;
      else                     idle_cnt <= idle_cnt + 1'b1;

      case (state)
        S_LEN_LO: if (accept) len_lo <= rx_byte;
        S_LEN_HI: begin
          if (accept) begin
            len      <= len_rx;
            byte_idx <= '0;
            word_idx <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        S_DATA: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            csum     <= csum ^ rx_byte;
`endif
            case (byte_idx)
              2'd0: asm_word[7:0]   <= rx_byte;
              2'd1: asm_word[15:8]  <= rx_byte;
              2'd2: asm_word[23:16] <= rx_byte;
              default: begin
                // Address wraps modulo the IMEM size by truncation.
                imem_we    <= 1'b1;
                imem_wdata <= {rx_byte, asm_word};
                imem_addr  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(word_idx);
                word_idx   <= word_idx + 16'd1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
